// File: rtl/uart_rx_fifo_sb_ctrl.sv
// uart_rx_fifo_sb_ctrl
//   Memory-mapped UART receiver. It contains a 2-flop input synchroniser, an
//   RX deserialiser FSM, a receive FIFO, a programmable frame format,
//   sticky error flags and a registered level interrupt.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   addr_i[31:0]          byte address (only [23:0] decoded)
//   req_i                 bus request
//   write_enable_i        write strobe, qualified by req_i
//   write_data_i[31:0]    write data
//   read_data_o[31:0]     registered read data (1-cycle latency)
//   interrupt_request_o   level interrupt (registered)
//   interrupt_return_i    end-of-handler pulse; clears error flags
//   rx_i                  serial input, idles high
//
// Bus handshake: the slave is always ready. Every cycle with req_i=1 is a
// complete transfer. A write lands on that edge. A read's data appears on
// read_data_o after that edge and is held until the next req_i cycle.
//
// Register map (byte offsets)
//   0x00 DATA   R   FIFO head (pops)
//   0x04 STATUS R   {count[15:8], 2'b0, parity_err, frame_err, overrun, busy, full, not_empty}
//   0x08 CTRL   RW  {err_ie, data_ie, rx_en, two_stop, parity_odd, parity_en}
//   0x0C DIV    RW  clocks per bit (writes below 8 ignored)
//   0x10 THR    RW  FIFO interrupt threshold (0 acts as 1)
//   0x14 ERRCLR W   W1C for STATUS[5:3]
//   0x24 SRST   W   soft reset of the whole block
module uart_rx_fifo_sb_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 17,
  parameter int DEFAULT_DIV = 10417
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic [31:0] write_data_i,
  input  logic        write_enable_i,
  output logic [31:0] read_data_o,
  output logic        interrupt_request_o,
  input  logic        interrupt_return_i,
  input  logic        rx_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [23:0] A_DATA   = 24'h000000;
  localparam logic [23:0] A_STATUS = 24'h000004;
  localparam logic [23:0] A_CTRL   = 24'h000008;
  localparam logic [23:0] A_DIV    = 24'h00000C;
  localparam logic [23:0] A_THR    = 24'h000010;
  localparam logic [23:0] A_ERRCLR = 24'h000014;
  localparam logic [23:0] A_SRST   = 24'h000024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // ---------------- bus decode ----------------
  logic [23:0] a;
  logic        wr, rd_data, srst;
  logic        unused_bits;

  assign a           = addr_i[23:0];
  assign wr          = req_i & write_enable_i;
  assign rd_data     = req_i & ~write_enable_i & (a == A_DATA);
  assign srst        = wr & (a == A_SRST);
  assign unused_bits = ^{addr_i[31:24], write_data_i};

  // ---------------- registers ----------------
  logic [5:0]       ctrl_q;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       thr_q;
  logic             parity_en, parity_odd, two_stop, rx_en, data_ie, err_ie;

  assign parity_en  = ctrl_q[0];
  assign parity_odd = ctrl_q[1];
  assign two_stop   = ctrl_q[2];
  assign rx_en      = ctrl_q[3];
  assign data_ie    = ctrl_q[4];
  assign err_ie     = ctrl_q[5];

  // ---------------- synchroniser ----------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------- RX engine ----------------
  rx_state_t        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, target;
  logic [2:0]       bit_q, bit_d;
  logic             stop_q, stop_d;   // first of two stop bits already taken
  logic [7:0]       shift_q, shift_d;
  logic             fe_q, fe_d, pe_q, pe_d;
  logic             done_q, done_d;   // high on the cycle after the last stop sample
  logic             tick, busy;

  assign busy   = (state_q != ST_IDLE);
  // The start bit is resampled half a bit in, every later bit a full bit on.
  assign target = (state_q == ST_START) ? (div_q >> 1) : div_q;
  assign tick   = (cnt_q == target - DIV_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + DIV_W'(1);
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_en && rx_prev_q && !rx_sync_q) begin
          state_d = ST_START;
          bit_d   = 3'd0;
          stop_d  = 1'b0;
          fe_d    = 1'b0;
          pe_d    = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = parity_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          // Even check fails on an odd ones count; parity_odd flips it.
          pe_d    = (^shift_q) ^ rx_sync_q ^ parity_odd;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (!rx_sync_q) fe_d = 1'b1;
          if (two_stop && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      shift_q <= 8'h00;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (srst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      shift_q <= 8'h00;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      done_q  <= done_d;
    end
  end

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          not_empty, full, pop, push, frame_ok;
  logic [15:0]   count_ext;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = rd_data & not_empty;
  assign frame_ok  = done_q & ~fe_q & ~pe_q;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push      = frame_ok & (~full | pop);
  assign count_ext = 16'(count_q);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q] <= shift_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (srst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // ---------------- flags ----------------
  logic       ov_q, fe_flag_q, pe_flag_q;
  logic       ov_set, fe_set, pe_set;
  logic [2:0] clr;

  assign ov_set = frame_ok & full & ~pop;
  assign fe_set = done_q & fe_q;
  assign pe_set = done_q & pe_q;
  assign clr    = (wr && a == A_ERRCLR) ? write_data_i[5:3] : 3'b000;

  // Set terms are OR-ed last so an error event beats a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ov_q      <= 1'b0;
      fe_flag_q <= 1'b0;
      pe_flag_q <= 1'b0;
    end else if (srst) begin
      ov_q      <= 1'b0;
      fe_flag_q <= 1'b0;
      pe_flag_q <= 1'b0;
    end else begin
      ov_q      <= (ov_q      & ~clr[0] & ~interrupt_return_i) | ov_set;
      fe_flag_q <= (fe_flag_q & ~clr[1] & ~interrupt_return_i) | fe_set;
      pe_flag_q <= (pe_flag_q & ~clr[2] & ~interrupt_return_i) | pe_set;
    end
  end

  // ---------------- config writes ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q <= 6'h38;
      div_q  <= DIV_W'(DEFAULT_DIV);
      thr_q  <= 8'd1;
    end else if (srst) begin
      ctrl_q <= 6'h38;
      div_q  <= DIV_W'(DEFAULT_DIV);
      thr_q  <= 8'd1;
    end else if (wr) begin
      if (a == A_CTRL) begin
        ctrl_q[5:3] <= write_data_i[5:3];
        // Frame format is frozen while a frame is in flight.
        if (!busy) ctrl_q[2:0] <= write_data_i[2:0];
      end
      if (a == A_DIV && !busy && write_data_i[DIV_W-1:0] >= DIV_W'(8))
        div_q <= write_data_i[DIV_W-1:0];
      if (a == A_THR)
        thr_q <= (write_data_i[7:0] == 8'd0) ? 8'd1 : write_data_i[7:0];
    end
  end

  // ---------------- read path and interrupt ----------------
  logic [31:0] rdata;

  always_comb begin
    rdata = 32'h0;
    case (a)
      A_DATA:   rdata = not_empty ? {24'h0, mem[rd_q]} : 32'h0;
      A_STATUS: rdata = {16'h0, count_ext[7:0], 2'b00, pe_flag_q, fe_flag_q,
                         ov_q, busy, full, not_empty};
      A_CTRL:   rdata = {26'h0, ctrl_q};
      A_DIV:    rdata = 32'(div_q);
      A_THR:    rdata = {24'h0, thr_q};
      default:  rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      read_data_o         <= 32'h0;
      interrupt_request_o <= 1'b0;
    end else begin
      if (req_i) read_data_o <= rdata;
      interrupt_request_o <= (data_ie & (count_ext >= {8'h0, thr_q})) |
                             (err_ie & (ov_q | fe_flag_q | pe_flag_q));
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_sb_ctrl.sv
// Directed bench for uart_rx_fifo_sb_ctrl. FIFO depth 4, DIV programmed to
// 16 after reset (reset default 20). Inputs change on the falling clock
// edge; outputs are sampled on the falling edge.
module tb_uart_rx_fifo_sb_ctrl;

  localparam int BIT = 16;
  localparam logic [31:0] A_DATA = 32'h00, A_STATUS = 32'h04, A_CTRL = 32'h08,
                          A_DIV = 32'h0C, A_THR = 32'h10, A_ERRCLR = 32'h14,
                          A_SRST = 32'h24;

  logic        clk, rst;
  logic [31:0] addr, wdata, rdata;
  logic        req, we, irq, irq_ret, rx;

  int n_chk = 0;
  int n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] v;

  uart_rx_fifo_sb_ctrl #(.FIFO_DEPTH(4), .DIV_W(17), .DEFAULT_DIV(20)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .req_i(req),
    .write_data_i(wdata), .write_enable_i(we), .read_data_o(rdata),
    .interrupt_request_o(irq), .interrupt_return_i(irq_ret), .rx_i(rx)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    d = rdata;
    req = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check_eq(tag, d, exp);
  endtask

  // Caller must be at a falling edge; the start bit begins immediately.
  task automatic send_frame(input logic [7:0] b, input logic par_en, input logic pbit,
                            input logic two, input logic stop1, input logic stop2);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    if (par_en) begin
      rx = pbit;
      repeat (BIT) @(negedge clk);
    end
    rx = stop1;
    repeat (BIT) @(negedge clk);
    if (two) begin
      rx = stop2;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    send_frame(b, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    irq_ret = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset read_data", rdata, 32'h0);
    check_eq("reset irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rd_chk("reset status", A_STATUS, 32'h0000_0000);
    rd_chk("reset ctrl", A_CTRL, 32'h38);
    rd_chk("reset div", A_DIV, 32'd20);
    rd_chk("reset thr", A_THR, 32'd1);

    // DIV programming, small values ignored
    bus_write(A_DIV, BIT);
    rd_chk("div write", A_DIV, BIT);
    bus_write(A_DIV, 5);
    rd_chk("div below 8 ignored", A_DIV, BIT);
    rd_chk("unmapped read", 32'h40, 32'h0);

    // Basic receive
    send_byte(8'hA5);
    rd_chk("basic status", A_STATUS, 32'h0101);
    check_eq("basic irq high", {31'h0, irq}, 32'h1);
    rd_chk("basic data", A_DATA, 32'hA5);
    rd_chk("basic status empty", A_STATUS, 32'h0000);
    check_eq("basic irq low", {31'h0, irq}, 32'h0);

    // Threshold and overrun
    bus_write(A_THR, 4);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    check_eq("thr irq below", {31'h0, irq}, 32'h0);
    send_byte(8'h04);
    check_eq("thr irq at 4", {31'h0, irq}, 32'h1);
    rd_chk("full status", A_STATUS, 32'h0403);
    send_byte(8'h05);
    rd_chk("overrun status", A_STATUS, 32'h040B);
    rd_chk("ovr data 1", A_DATA, 32'h01);
    rd_chk("ovr data 2", A_DATA, 32'h02);
    rd_chk("ovr data 3", A_DATA, 32'h03);
    rd_chk("ovr data 4", A_DATA, 32'h04);
    rd_chk("empty data read", A_DATA, 32'h00);
    rd_chk("ovr sticky", A_STATUS, 32'h0008);
    bus_write(A_ERRCLR, 32'h08);
    rd_chk("errclr ovr", A_STATUS, 32'h0000);
    bus_write(A_THR, 0);
    rd_chk("thr zero as one", A_THR, 32'd1);

    // Odd parity
    bus_write(A_CTRL, 32'h3B);
    rd_chk("ctrl parity", A_CTRL, 32'h3B);
    @(negedge clk); send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    rd_chk("parity ok status", A_STATUS, 32'h0101);
    rd_chk("parity ok data", A_DATA, 32'h03);
    @(negedge clk); send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    rd_chk("parity err status", A_STATUS, 32'h0020);
    check_eq("parity err irq", {31'h0, irq}, 32'h1);
    @(negedge clk); irq_ret = 1'b1;
    @(negedge clk); irq_ret = 1'b0;
    rd_chk("irq return clears", A_STATUS, 32'h0000);
    check_eq("irq return irq low", {31'h0, irq}, 32'h0);

    // Stop-bit errors
    bus_write(A_CTRL, 32'h38);
    @(negedge clk); send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    rd_chk("stop low frame_err", A_STATUS, 32'h0010);
    bus_write(A_ERRCLR, 32'h10);
    bus_write(A_CTRL, 32'h3C);
    @(negedge clk); send_frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rd_chk("2nd stop low frame_err", A_STATUS, 32'h0010);
    bus_write(A_ERRCLR, 32'h38);
    @(negedge clk); send_frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    rd_chk("two stop ok status", A_STATUS, 32'h0101);
    rd_chk("two stop ok data", A_DATA, 32'h66);
    bus_write(A_CTRL, 32'h38);

    // Push/pop collision with a full FIFO
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h11 + 8'(i));
      exp_q.push_back(8'h11 + 8'(i));
    end
    rd_chk("collision pre status", A_STATUS, 32'h0403);
    @(negedge clk);
    fork
      send_frame(8'h15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        // Read lands on the push edge: 2 + DIV/2 + 9*DIV + 1 = 155 clocks in.
        repeat (154) @(negedge clk);
        bus_read(A_DATA, v);
      end
    join
    exp_q.push_back(8'h15);
    check_eq("collision read", v, {24'h0, exp_q.pop_front()});
    repeat (4) @(negedge clk);
    rd_chk("collision status", A_STATUS, 32'h0403);
    while (exp_q.size() > 0) rd_chk("collision order", A_DATA, {24'h0, exp_q.pop_front()});
    rd_chk("collision drained", A_STATUS, 32'h0000);

    // Glitch rejected
    @(negedge clk); rx = 1'b0;
    repeat (3) @(negedge clk); rx = 1'b1;
    repeat (200) @(negedge clk);
    rd_chk("glitch ignored", A_STATUS, 32'h0000);

    // DIV write while busy ignored
    @(negedge clk);
    fork
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        repeat (60) @(negedge clk);
        bus_write(A_DIV, 32);
      end
    join
    repeat (4) @(negedge clk);
    rd_chk("div busy ignored", A_DIV, BIT);
    rd_chk("div busy frame data", A_DATA, 32'h3C);

    // SRST mid-frame
    bus_write(A_CTRL, 32'h18);
    @(negedge clk); rx = 1'b0;
    repeat (40) @(negedge clk);
    bus_write(A_SRST, 32'h1);
    rd_chk("srst status", A_STATUS, 32'h0000);
    rd_chk("srst ctrl", A_CTRL, 32'h38);
    rd_chk("srst div", A_DIV, 32'd20);
    @(negedge clk); rx = 1'b1;
    repeat (300) @(negedge clk);
    rd_chk("srst no partial", A_STATUS, 32'h0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
